// File: rtl/rs10_8_pkg.sv
// Shared types, constants and GF(2^8) arithmetic for the RS(10,8) erasure decoding path.
package rs10_8_pkg;
  localparam int SYM_W = 8;
  localparam int N_SYM = 10;
  localparam logic [8:0] GF_POLY = 9'h11D;

  typedef enum logic [1:0] {NE = 2'b00, CE = 2'b01, DUE = 2'b10} status_e;
  typedef enum logic [2:0] {IDLE, CALC, INV, APPLY, DONE} state_e;

  // X_k = alpha^(9-k)
  localparam logic [SYM_W-1:0] LOC_X [N_SYM] = '{
    8'h3A, 8'h1D, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                              input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] p;
    logic [SYM_W-1:0] aa;
    p  = '0;
    aa = a;
    for (int k = 0; k < SYM_W; k++) begin
      if (b[k]) p = p ^ aa;
      aa = aa[SYM_W-1] ? ((aa << 1) ^ GF_POLY[SYM_W-1:0]) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [SYM_W-1:0] gf_sq(input logic [SYM_W-1:0] a);
    return gf_mul(a, a);
  endfunction

  // Out-of-range locations map to 0; such requests are rejected as illegal anyway.
  function automatic logic [SYM_W-1:0] loc_x(input logic [3:0] idx);
    if (idx < 4'(N_SYM)) return LOC_X[idx];
    return '0;
  endfunction
endpackage

// File: rtl/rs_gf_inv_iter.sv
// Iterative Fermat inverse: den^254 built from seven square-and-multiply steps.
module rs_gf_inv_iter
  import rs10_8_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SYM_W-1:0] den,
  output logic             done,
  output logic [SYM_W-1:0] inv
);
  logic             busy;
  logic [2:0]       cnt;
  logic [SYM_W-1:0] base;
  logic [SYM_W-1:0] acc;
  logic [SYM_W-1:0] base_sq;

  assign base_sq = gf_sq(base);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      base <= '0;
      acc  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      base <= den;
      acc  <= 8'h01;
    end else if (busy) begin
      base <= base_sq;
      acc  <= gf_mul(acc, base_sq);
      cnt  <= cnt + 3'd1;
      if (cnt == 3'd6) busy <= 1'b0;
    end
  end

  // High during the seventh step; inv is final from the following cycle.
  assign done = busy && (cnt == 3'd6);
  assign inv  = acc;
endmodule

// File: rtl/rs_erasure_corrector.sv
// RS(10,8) erasure corrector: solves up to two erasure magnitudes and patches the word.
// States: IDLE accept | CALC num/den + legality | INV invert den | APPLY patch word | DONE hold result
module rs_erasure_corrector
  import rs10_8_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SYM_W*N_SYM-1:0] codeword_in,
  input  logic [SYM_W-1:0]       syndrome0_in,
  input  logic [SYM_W-1:0]       syndrome1_in,
  input  logic [1:0]             era_num_in,
  input  logic [3:0]             first_loc_in,
  input  logic [3:0]             second_loc_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SYM_W*N_SYM-1:0] codeword_out,
  output logic [1:0]             status_out
);
  localparam int W = SYM_W * N_SYM;

  state_e           state, state_nx;
  logic [W-1:0]     word_q, cw_out_q, apply_word;
  logic [SYM_W-1:0] s0_q, s1_q, num_q;
  logic [1:0]       era_q;
  logic [3:0]       i_q, j_q;
  logic             due_q, out_valid_q, illegal, inv_start, inv_done;
  status_e          status_q, apply_status;
  logic [SYM_W-1:0] xi, xj, num_c, den_c, inv_val, e_i, e_j;

  function automatic logic [W-1:0] flip_sym(input logic [W-1:0] w, input logic [3:0] k,
                                            input logic [SYM_W-1:0] e);
    logic [W-1:0] r;
    r = w;
    for (int m = 0; m < N_SYM; m++)
      if (k == 4'(m)) r[(N_SYM-1-m)*SYM_W +: SYM_W] = r[(N_SYM-1-m)*SYM_W +: SYM_W] ^ e;
    return r;
  endfunction

  assign xi    = loc_x(i_q);
  assign xj    = loc_x(j_q);
  assign num_c = s1_q ^ gf_mul(s0_q, xj);
  assign den_c = xi ^ xj;

  always_comb begin
    illegal = 1'b1;
    unique case (era_q)
      2'd0:    illegal = 1'b0;
      2'd1:    illegal = (i_q > 4'd9);
      2'd2:    illegal = (i_q >= j_q) || (j_q > 4'd9);
      default: illegal = 1'b1;
    endcase
  end

  assign inv_start = (state == CALC) && (era_q == 2'd2) && !illegal;

  rs_gf_inv_iter u_inv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (inv_start),
    .den   (den_c),
    .done  (inv_done),
    .inv   (inv_val)
  );

  assign e_i = gf_mul(num_q, inv_val);
  assign e_j = s0_q ^ e_i;

  always_comb begin
    apply_word   = word_q;
    apply_status = DUE;
    if (!due_q) begin
      unique case (era_q)
        2'd0: apply_status = (s0_q == '0 && s1_q == '0) ? NE : DUE;
        2'd1: begin
          if (s1_q == gf_mul(s0_q, xi)) begin
            apply_status = CE;
            apply_word   = flip_sym(word_q, i_q, s0_q);
          end
        end
        2'd2: begin
          apply_status = CE;
          apply_word   = flip_sym(flip_sym(word_q, i_q, e_i), j_q, e_j);
        end
        default: apply_status = DUE;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = CALC;
      CALC:    state_nx = inv_start ? INV : APPLY;
      INV:     if (inv_done) state_nx = APPLY;
      APPLY:   state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q      <= '0;
      s0_q        <= '0;
      s1_q        <= '0;
      era_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      num_q       <= '0;
      due_q       <= 1'b0;
      cw_out_q    <= '0;
      status_q    <= NE;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            word_q <= codeword_in;
            s0_q   <= syndrome0_in;
            s1_q   <= syndrome1_in;
            era_q  <= era_num_in;
            i_q    <= first_loc_in;
            j_q    <= second_loc_in;
            due_q  <= 1'b0;
          end
        end
        CALC: begin
          num_q <= num_c;
          due_q <= illegal;
        end
        APPLY: begin
          cw_out_q    <= apply_word;
          status_q    <= apply_status;
          out_valid_q <= 1'b1;
        end
        DONE:    if (out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready     = (state == IDLE);
  assign out_valid    = out_valid_q;
  assign codeword_out = cw_out_q;
  assign status_out   = status_q;
endmodule

// File: tb/tb_rs_erasure_corrector.sv
// Directed bench for rs_erasure_corrector against a log/antilog-table GF model.
module tb_rs_erasure_corrector;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [79:0] codeword_in = '0;
  logic [79:0] codeword_out;
  logic [7:0]  syndrome0_in = '0, syndrome1_in = '0;
  logic [1:0]  era_num_in = '0;
  logic [1:0]  status_out;
  logic [3:0]  first_loc_in = '0, second_loc_in = '0;

  int n_checks = 0;
  int n_fail = 0;
  int exp_t [255];
  int log_t [256];
  logic [79:0] exp_word = '0;
  logic [1:0]  exp_status = '0;
  bit          armed = 1'b0;

  always #5 clk = ~clk;

  rs_erasure_corrector dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .codeword_in   (codeword_in),
    .syndrome0_in  (syndrome0_in),
    .syndrome1_in  (syndrome1_in),
    .era_num_in    (era_num_in),
    .first_loc_in  (first_loc_in),
    .second_loc_in (second_loc_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .codeword_out  (codeword_out),
    .status_out    (status_out)
  );

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, want);
    end
  endtask

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return 8'(exp_t[(log_t[a] + log_t[b]) % 255]);
  endfunction

  function automatic logic [7:0] xloc(input int k);
    return 8'(exp_t[9-k]);
  endfunction

  function automatic logic [7:0] sym(input logic [79:0] w, input int k);
    return w[79-8*k -: 8];
  endfunction

  function automatic logic [79:0] flip(input logic [79:0] w, input int k, input logic [7:0] e);
    logic [79:0] r;
    r = w;
    r[79-8*k -: 8] = r[79-8*k -: 8] ^ e;
    return r;
  endfunction

  function automatic logic [7:0] syn0(input logic [79:0] w);
    logic [7:0] s;
    s = 8'h00;
    for (int k = 0; k < 10; k++) s = s ^ sym(w, k);
    return s;
  endfunction

  function automatic logic [7:0] syn1(input logic [79:0] w);
    logic [7:0] s;
    s = 8'h00;
    for (int k = 0; k < 10; k++) s = s ^ mul(sym(w, k), xloc(k));
    return s;
  endfunction

  // Exhaustive search for the pair of magnitudes that explains both syndromes.
  task automatic solve2(input logic [7:0] s0, input logic [7:0] s1, input int i, input int j,
                        output logic [7:0] ei, output logic [7:0] ej);
    ei = 8'h00;
    ej = 8'h00;
    for (int e = 0; e < 256; e++)
      if ((mul(8'(e), xloc(i)) ^ mul(8'(e) ^ s0, xloc(j))) == s1) begin
        ei = 8'(e);
        ej = 8'(e) ^ s0;
      end
  endtask

  task automatic model(input logic [79:0] w, input logic [7:0] s0, input logic [7:0] s1,
                       input logic [1:0] era, input logic [3:0] i, input logic [3:0] j,
                       output logic [79:0] ow, output logic [1:0] st, output int lat);
    logic [7:0] ei, ej;
    ow  = w;
    st  = 2'b10;
    lat = 2;
    if (era == 2'd0) begin
      st = (s0 == 8'h00 && s1 == 8'h00) ? 2'b00 : 2'b10;
    end else if (era == 2'd1 && i <= 4'd9) begin
      if (s1 == mul(s0, xloc(int'(i)))) begin
        st = 2'b01;
        ow = flip(w, int'(i), s0);
      end
    end else if (era == 2'd2 && i < j && j <= 4'd9) begin
      solve2(s0, s1, int'(i), int'(j), ei, ej);
      ow  = flip(flip(w, int'(i), ei), int'(j), ej);
      st  = 2'b01;
      lat = 9;
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      check("spurious_out_valid", 80'(armed), 80'd1);
      check("codeword_out", codeword_out, exp_word);
      check("status_out", 80'(status_out), 80'(exp_status));
    end
  end

  task automatic drive(input logic [79:0] w, input logic [7:0] s0, input logic [7:0] s1,
                       input logic [1:0] era, input logic [3:0] i, input logic [3:0] j);
    codeword_in   = w;
    syndrome0_in  = s0;
    syndrome1_in  = s1;
    era_num_in    = era;
    first_loc_in  = i;
    second_loc_in = j;
  endtask

  task automatic run_txn(input string tag, input logic [79:0] w, input logic [7:0] s0,
                         input logic [7:0] s1, input logic [1:0] era, input logic [3:0] i,
                         input logic [3:0] j, input int hold);
    int lat, n;
    logic [79:0] ew;
    logic [1:0]  es;
    model(w, s0, s1, era, i, j, ew, es, lat);
    @(negedge clk);
    check({tag, "_in_ready_idle"}, 80'(in_ready), 80'd1);
    drive(w, s0, s1, era, i, j);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    exp_word   = ew;
    exp_status = es;
    armed      = 1'b1;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 80'(n), 80'(lat));
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      drive(~w, 8'h55, 8'hAA, 2'd1, 4'd1, 4'd2);
      in_valid = 1'b1;
      check({tag, "_in_ready_busy"}, 80'(in_ready), 80'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    armed     = 1'b0;
    check({tag, "_valid_drop"}, 80'(out_valid), 80'd0);
    check({tag, "_back_idle"}, 80'(in_ready), 80'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v;
    logic [79:0] data, cw, rw, w4;
    logic [7:0]  ei, ej;

    v = 1;
    for (int e = 0; e < 255; e++) begin
      exp_t[e] = v;
      log_t[v] = e;
      v = v << 1;
      if (v >= 256) v = v ^ 'h11D;
    end
    log_t[0] = 0;

    #1 rst_n = 1'b0;
    #2;
    check("rst_in_ready", 80'(in_ready), 80'd1);
    check("rst_out_valid", 80'(out_valid), 80'd0);
    check("rst_codeword_out", codeword_out, 80'd0);
    check("rst_status", 80'(status_out), 80'd0);
    @(negedge clk);
    rst_n = 1'b1;

    check("pin_x0", 80'(xloc(0)), 80'h3A);
    check("pin_mul_5a_a6", 80'(mul(8'h5A, xloc(3))), 80'h03);

    run_txn("zero_ne", 80'd0, 8'h00, 8'h00, 2'd0, 4'd0, 4'd0, 0);
    check("pin_zero_status", 80'(exp_status), 80'd0);

    rw = flip(flip(80'd0, 0, 8'h01), 9, 8'h80);
    check("pin_s0_0_9", 80'(syn0(rw)), 80'h81);
    check("pin_s1_0_9", 80'(syn1(rw)), 80'hBA);
    run_txn("two_0_9", rw, 8'h81, 8'hBA, 2'd2, 4'd0, 4'd9, 0);
    check("pin_two_0_9_word", exp_word, 80'd0);
    check("pin_two_0_9_status", 80'(exp_status), 80'd1);

    w4 = flip(80'd0, 3, 8'h5A);
    run_txn("one_ce", w4, 8'h5A, 8'h03, 2'd1, 4'd3, 4'd0, 0);
    check("pin_one_ce_word", exp_word, 80'd0);
    run_txn("one_due", w4, 8'h5A, 8'h00, 2'd1, 4'd3, 4'd0, 0);
    check("pin_one_due_status", 80'(exp_status), 80'd2);
    check("pin_one_due_word", exp_word, w4);

    run_txn("ill_eq", w4, 8'h12, 8'h34, 2'd2, 4'd4, 4'd4, 0);
    run_txn("ill_rev", w4, 8'h12, 8'h34, 2'd2, 4'd7, 4'd2, 0);
    run_txn("ill_era3", w4, 8'h5A, 8'h03, 2'd3, 4'd3, 4'd5, 0);
    run_txn("ill_loc12", w4, 8'h5A, 8'h03, 2'd1, 4'd12, 4'd0, 0);

    data = 80'h11223344556677880000;
    solve2(syn0(data), syn1(data), 8, 9, ei, ej);
    cw = flip(flip(data, 8, ei), 9, ej);
    check("pin_cw_s0", 80'(syn0(cw)), 80'd0);
    check("pin_cw_s1", 80'(syn1(cw)), 80'd0);

    rw = flip(flip(cw, 2, 8'hA5), 5, 8'h3C);
    run_txn("two_bp", rw, syn0(rw), syn1(rw), 2'd2, 4'd2, 4'd5, 5);
    check("pin_two_bp_restores", exp_word, cw);
    run_txn("era0_due", rw, syn0(rw), syn1(rw), 2'd0, 4'd0, 4'd0, 0);

    rw = flip(cw, 6, 8'h0F);
    run_txn("one_cw", rw, syn0(rw), syn1(rw), 2'd1, 4'd6, 4'd0, 1);
    check("pin_one_cw_restores", exp_word, cw);

    rw = flip(cw, 4, 8'h77);
    run_txn("zero_mag", rw, syn0(rw), syn1(rw), 2'd2, 4'd4, 4'd7, 0);
    check("pin_zero_mag_restores", exp_word, cw);

    rw = flip(flip(cw, 1, 8'hC3), 8, 8'h9E);
    @(negedge clk);
    drive(rw, syn0(rw), syn1(rw), 2'd2, 4'd1, 4'd8);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 80'(out_valid), 80'd0);
    check("midrst_in_ready", 80'(in_ready), 80'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_output", 80'(out_valid), 80'd0);
    run_txn("after_rst", rw, syn0(rw), syn1(rw), 2'd2, 4'd1, 4'd8, 0);
    check("pin_after_rst_restores", exp_word, cw);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
